// File: rtl/intr_pkg.sv
// Shared types and constants for the RAT MCU interrupt sequencer.
package intr_pkg;

   localparam int MAX_SRC   = 8;
   localparam int VEC_W_DEF = 10;
   localparam logic [VEC_W_DEF-1:0] VEC_BASE_DEF = 10'h3F8;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      SAVE,
      ISR,
      RESTORE
   } intr_state_t;

   // Index width for an n-source encoder; a single source still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// Fixed-priority encoder: the lowest set index wins.
module intr_prio_enc
   import intr_pkg::*;
#(
   parameter int N_SRC = 4,
   parameter int IDX_W = idx_width(N_SRC)
) (
   input  logic [N_SRC-1:0] req,
   output logic             valid,
   output logic [IDX_W-1:0] idx
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int k = N_SRC - 1; k >= 0; k--) begin
         if (req[k]) begin
            valid = 1'b1;
            idx   = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/intr_sequencer.sv
// Interrupt sequencer for the RAT MCU: latches/arbitrates interrupt sources,
// handshakes with the control unit, owns the I flag and sequences the C/Z
// shadow save on entry and the restore on RETIE.
// Build option: define INTR_EDGE_EN for edge-detected, latched (pending)
// sources; without it sources are level-sensitive and must drop before RETIE.
module intr_sequencer
   import intr_pkg::*;
#(
   parameter int               N_SRC    = 4,
   parameter int               VEC_W    = VEC_W_DEF,
   parameter logic [VEC_W-1:0] VEC_BASE = VEC_W'(VEC_BASE_DEF)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [N_SRC-1:0] IRQ,
   input  logic [N_SRC-1:0] MASK,
   input  logic             I_SET,
   input  logic             I_CLR,
   input  logic             FETCH,
   input  logic             INTR_ACK,
   input  logic             RETIE,
   output logic             INTR_REQ,
   output logic [VEC_W-1:0] INTR_VEC,
   output logic             I_FLAG,
   output logic             IN_ISR,
   output logic             FLG_SHAD_LD,
   output logic             FLG_LD_SEL,
   output logic             FLG_RESTORE
);

   localparam int IDX_W = idx_width(N_SRC);

   intr_state_t      state;
   logic [N_SRC-1:0] eligible;
   logic             enc_valid;
   logic [IDX_W-1:0] enc_idx;
   logic             grant;

   // A grant needs a live eligible source; an ACK with nothing left is ignored.
   assign grant = (state == REQ) && INTR_ACK && enc_valid;

`ifdef INTR_EDGE_EN
   logic [N_SRC-1:0] irq_p1;
   logic [N_SRC-1:0] pend;
   logic [N_SRC-1:0] grant_clr;

   assign grant_clr = grant ? (N_SRC'(1) << enc_idx) : '0;
   assign eligible  = pend & MASK;

   // Rising-edge capture; a new edge in the grant cycle outranks the clear.
   always_ff @(posedge CLK) begin
      if (RST) begin
         irq_p1 <= '0;
         pend   <= '0;
      end else begin
         irq_p1 <= IRQ;
         pend   <= (pend & ~grant_clr) | (IRQ & ~irq_p1);
      end
   end
`else
   assign eligible = IRQ & MASK;
`endif

   intr_prio_enc #(
      .N_SRC (N_SRC),
      .IDX_W (IDX_W)
   ) u_prio_enc (
      .req   (eligible),
      .valid (enc_valid),
      .idx   (enc_idx)
   );

   // Global interrupt enable: RESTORE sets, grant clears, CLI beats SEI.
   always_ff @(posedge CLK) begin
      if (RST) begin
         I_FLAG <= 1'b0;
      end else if (state == RESTORE) begin
         I_FLAG <= 1'b1;
      end else if (grant || I_CLR) begin
         I_FLAG <= 1'b0;
      end else if (I_SET) begin
         I_FLAG <= 1'b1;
      end
   end

   // Entry/exit sequencer with all handshake and strobe outputs registered.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= IDLE;
         INTR_REQ    <= 1'b0;
         INTR_VEC    <= VEC_BASE;
         IN_ISR      <= 1'b0;
         FLG_SHAD_LD <= 1'b0;
         FLG_LD_SEL  <= 1'b0;
         FLG_RESTORE <= 1'b0;
      end else begin
         FLG_SHAD_LD <= 1'b0;
         FLG_LD_SEL  <= 1'b0;
         FLG_RESTORE <= 1'b0;
         case (state)
            IDLE: begin
               if (I_FLAG && enc_valid && FETCH) begin
                  state    <= REQ;
                  INTR_REQ <= 1'b1;
               end
            end
            REQ: begin
               if (grant) begin
                  state       <= SAVE;
                  INTR_REQ    <= 1'b0;
                  INTR_VEC    <= VEC_BASE + VEC_W'(enc_idx);
                  FLG_SHAD_LD <= 1'b1;
               end else if (I_CLR || !I_FLAG || !enc_valid) begin
                  // Withdraw: CLI (also one coinciding with FETCH) or the source went away.
                  state    <= IDLE;
                  INTR_REQ <= 1'b0;
               end
            end
            SAVE: begin
               state  <= ISR;
               IN_ISR <= 1'b1;
            end
            ISR: begin
               if (RETIE) begin
                  state       <= RESTORE;
                  IN_ISR      <= 1'b0;
                  FLG_LD_SEL  <= 1'b1;
                  FLG_RESTORE <= 1'b1;
               end
            end
            RESTORE: begin
               state <= IDLE;
            end
            default: begin
               state    <= IDLE;
               INTR_REQ <= 1'b0;
               IN_ISR   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_intr_sequencer.sv
// Scoreboard bench for intr_sequencer: the stimulus pushes expected grant
// vectors and restore events; a negedge monitor pops them whenever the DUT
// strobes FLG_SHAD_LD or FLG_RESTORE. Directed timing checks run inline.
module tb_intr_sequencer;

   logic       CLK;
   logic       RST;
   logic [3:0] IRQ;
   logic [3:0] MASK;
   logic       I_SET;
   logic       I_CLR;
   logic       FETCH;
   logic       INTR_ACK;
   logic       RETIE;
   logic       INTR_REQ;
   logic [9:0] INTR_VEC;
   logic       I_FLAG;
   logic       IN_ISR;
   logic       FLG_SHAD_LD;
   logic       FLG_LD_SEL;
   logic       FLG_RESTORE;

   int n_checks = 0;
   int n_err    = 0;

   logic [9:0] exp_vec_q[$];
   int         exp_restore = 0;
   logic       prev_shad   = 1'b0;

   intr_sequencer dut (
      .CLK         (CLK),
      .RST         (RST),
      .IRQ         (IRQ),
      .MASK        (MASK),
      .I_SET       (I_SET),
      .I_CLR       (I_CLR),
      .FETCH       (FETCH),
      .INTR_ACK    (INTR_ACK),
      .RETIE       (RETIE),
      .INTR_REQ    (INTR_REQ),
      .INTR_VEC    (INTR_VEC),
      .I_FLAG      (I_FLAG),
      .IN_ISR      (IN_ISR),
      .FLG_SHAD_LD (FLG_SHAD_LD),
      .FLG_LD_SEL  (FLG_LD_SEL),
      .FLG_RESTORE (FLG_RESTORE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge(s).
   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // FETCH in IDLE, then ACK in REQ; checks latency of REQ, vector and entry.
   task automatic enter(input logic [9:0] vec, input string tag);
      FETCH = 1'b1;
      tick(1);
      FETCH = 1'b0;
      check({tag, "_req_high"}, 32'(INTR_REQ), 32'd1);
      exp_vec_q.push_back(vec);
      INTR_ACK = 1'b1;
      tick(1);
      INTR_ACK = 1'b0;
      check({tag, "_vec"}, 32'(INTR_VEC), 32'(vec));
      check({tag, "_iflag_clr"}, 32'(I_FLAG), 32'd0);
      tick(1);
      check({tag, "_in_isr"}, 32'(IN_ISR), 32'd1);
      check({tag, "_shad_one_cycle"}, 32'(FLG_SHAD_LD), 32'd0);
   endtask

   // RETIE in ISR; strobes during r+1, I flag back at r+2.
   task automatic leave(input string tag);
      exp_restore++;
      RETIE = 1'b1;
      tick(1);
      RETIE = 1'b0;
      check({tag, "_restore_r1"}, 32'(FLG_RESTORE), 32'd1);
      check({tag, "_iflag_r1"}, 32'(I_FLAG), 32'd0);
      tick(1);
      check({tag, "_iflag_r2"}, 32'(I_FLAG), 32'd1);
      check({tag, "_restore_off"}, 32'(FLG_RESTORE), 32'd0);
   endtask

   // Monitor: every shadow load must match a queued grant, every restore a queued RETIE.
   always @(negedge CLK) begin
      if (!RST) begin
         if (FLG_SHAD_LD) begin
            n_checks++;
            if (prev_shad) begin
               n_err++;
               $display("FAIL shad_pulse_width: got 2+ cycles required 1");
            end else if (exp_vec_q.size() == 0) begin
               n_err++;
               $display("FAIL shad_unexpected: got shadow load vec=%0h required none", INTR_VEC);
            end else begin
               logic [9:0] ev;
               ev = exp_vec_q.pop_front();
               if (INTR_VEC !== ev || I_FLAG !== 1'b0 || INTR_REQ !== 1'b0) begin
                  n_err++;
                  $display("FAIL grant_vec: got vec=%0h i=%0b req=%0b required vec=%0h i=0 req=0",
                           INTR_VEC, I_FLAG, INTR_REQ, ev);
               end
            end
         end
         if (FLG_RESTORE || FLG_LD_SEL) begin
            n_checks++;
            if (exp_restore == 0) begin
               n_err++;
               $display("FAIL restore_unexpected: got restore=%0b ld_sel=%0b required none",
                        FLG_RESTORE, FLG_LD_SEL);
            end else begin
               exp_restore--;
               if (!(FLG_RESTORE && FLG_LD_SEL)) begin
                  n_err++;
                  $display("FAIL restore_pair: got restore=%0b ld_sel=%0b required 1 1",
                           FLG_RESTORE, FLG_LD_SEL);
               end
            end
         end
      end
      prev_shad <= FLG_SHAD_LD && !RST;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1; IRQ = '0; MASK = '0; I_SET = 1'b0; I_CLR = 1'b0;
      FETCH = 1'b0; INTR_ACK = 1'b0; RETIE = 1'b0;
      tick(3);
      RST = 1'b0;

      // Reset state
      check("rst_req", 32'(INTR_REQ), 32'd0);
      check("rst_vec", 32'(INTR_VEC), 32'h3F8);
      check("rst_iflag", 32'(I_FLAG), 32'd0);
      check("rst_in_isr", 32'(IN_ISR), 32'd0);
      check("rst_strobes", 32'({FLG_SHAD_LD, FLG_LD_SEL, FLG_RESTORE}), 32'd0);

      // Basic entry/exit on source 2
      MASK = 4'b1111;
      I_SET = 1'b1; tick(1); I_SET = 1'b0;
      check("sei", 32'(I_FLAG), 32'd1);
      IRQ[2] = 1'b1; tick(1);
      enter(10'h3FA, "basic");
      IRQ = '0; tick(1);
      leave("basic");

      // Priority: sources 3 and 1 together, 1 first then 3
      IRQ = 4'b1010; tick(1);
      enter(10'h3F9, "prio1");
      IRQ[1] = 1'b0; tick(1);
      leave("prio1");
      enter(10'h3FB, "prio3");
      IRQ = '0; tick(1);
      leave("prio3");
`ifdef INTR_EDGE_EN
      check("prio_pend_empty", 32'(dut.pend), 32'd0);
`endif

      // Mask and disable
      MASK = 4'b1110;
      IRQ[0] = 1'b1; tick(1);
      FETCH = 1'b1; tick(2);
      check("masked_no_req", 32'(INTR_REQ), 32'd0);
      FETCH = 1'b0;
      I_CLR = 1'b1; tick(1); I_CLR = 1'b0;
      check("cli", 32'(I_FLAG), 32'd0);
      MASK = 4'b1111;
      FETCH = 1'b1; tick(2);
      check("disabled_no_req", 32'(INTR_REQ), 32'd0);
      FETCH = 1'b0;
      I_SET = 1'b1; I_CLR = 1'b1; tick(1); I_SET = 1'b0; I_CLR = 1'b0;
      check("cli_over_sei", 32'(I_FLAG), 32'd0);
      I_SET = 1'b1; tick(1); I_SET = 1'b0;
      check("sei_no_req_yet", 32'(INTR_REQ), 32'd0);
      enter(10'h3F8, "unmask");
      IRQ = '0; tick(1);
      leave("unmask");

      // Withdraw by CLI while requesting
      IRQ[3] = 1'b1; tick(1);
      FETCH = 1'b1; tick(1); FETCH = 1'b0;
      check("wd_req", 32'(INTR_REQ), 32'd1);
      I_CLR = 1'b1; INTR_ACK = 1'b0; tick(1); I_CLR = 1'b0;
      check("wd_req_drop", 32'(INTR_REQ), 32'd0);
      tick(2);
      check("wd_no_isr", 32'(IN_ISR), 32'd0);
`ifdef INTR_EDGE_EN
      check("wd_pend_kept", 32'(dut.pend), 32'h8);
`endif
      I_SET = 1'b1; tick(1); I_SET = 1'b0;
      enter(10'h3FB, "wd");
      IRQ = '0; tick(1);
      leave("wd");

`ifdef INTR_EDGE_EN
      // New edge on source 1 in the very cycle it is granted
      IRQ[1] = 1'b1; tick(1); IRQ[1] = 1'b0; tick(1);
      FETCH = 1'b1; tick(1); FETCH = 1'b0;
      check("sim_req", 32'(INTR_REQ), 32'd1);
      exp_vec_q.push_back(10'h3F9);
      INTR_ACK = 1'b1; IRQ[1] = 1'b1; tick(1); INTR_ACK = 1'b0;
      check("sim_pend_kept", 32'(dut.pend), 32'h2);
      tick(1);
      leave("sim1");
      enter(10'h3F9, "sim2");
      IRQ = '0; tick(1);
      leave("sim2");
      check("sim_pend_empty", 32'(dut.pend), 32'd0);
`endif

      // Reset while in ISR
      IRQ[2] = 1'b1; tick(1);
      enter(10'h3FA, "rst_isr");
      IRQ = '0;
      RST = 1'b1; tick(1); RST = 1'b0;
      check("rst_isr_vec", 32'(INTR_VEC), 32'h3F8);
      check("rst_isr_flags", 32'({INTR_REQ, I_FLAG, IN_ISR}), 32'd0);
      check("rst_isr_strobes", 32'({FLG_SHAD_LD, FLG_LD_SEL, FLG_RESTORE}), 32'd0);
      tick(3);
      check("rst_isr_idle", 32'({IN_ISR, FLG_RESTORE}), 32'd0);

      // Ignored RETIE outside ISR and ACK outside REQ
      RETIE = 1'b1; INTR_ACK = 1'b1; tick(1); RETIE = 1'b0; INTR_ACK = 1'b0;
      tick(2);
      check("stray_ignored", 32'({IN_ISR, INTR_REQ, I_FLAG}), 32'd0);

      tick(2);
      check("sb_vec_drained", 32'(exp_vec_q.size()), 32'd0);
      check("sb_restore_drained", 32'(exp_restore), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/intr_sequencer.md
# intr_sequencer

Interrupt sequencer for the RAT MCU. It latches interrupt events from up to `N_SRC` sources and arbitrates them by fixed priority. It handshakes with the control unit at instruction boundaries and sequences the C/Z flag shadow save on interrupt entry and the restore on `RETIE`. It sits between the I/O interrupt lines, the control unit FSM and the FLAGS block. It owns the global interrupt enable (I flag) and the flag shadow/restore strobes.

## Interface
Parameters:
- `N_SRC`, 4: number of interrupt sources, 1..8.
- `VEC_W`, 10: program-address width.
- `VEC_BASE`, 10'h3F8: vector of source 0. Source k vectors to `VEC_BASE + k`.

Ports:
- `CLK` in 1: system clock; all state updates on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `IRQ` in N_SRC: raw interrupt lines, synchronous to `CLK`.
- `MASK` in N_SRC: per-source enable, where 1 = enabled.
- `I_SET` in 1: SEI executing (one-cycle pulse).
- `I_CLR` in 1: CLI executing (one-cycle pulse).
- `FETCH` in 1: control unit is at an instruction boundary.
- `INTR_ACK` in 1: control unit is entering its interrupt state.
- `RETIE` in 1: RETIE executing (one-cycle pulse).
- `INTR_REQ` out 1: interrupt request to the control unit.
- `INTR_VEC` out VEC_W: vector to load into the PC.
- `I_FLAG` out 1: global interrupt enable.
- `IN_ISR` out 1: a service routine is active.
- `FLG_SHAD_LD` out 1: copy the live C/Z flags into the shadow.
- `FLG_LD_SEL` out 1: select the shadow as the flag load source.
- `FLG_RESTORE` out 1: ORed at top level into `FLG_C_LD` and `FLG_Z_LD`.

## Operation
- **Pending register `PEND[N_SRC]`:**
  - Bit k is set on a rising edge of `IRQ[k]`, detected against a registered copy of `IRQ`.
  - Bit k is cleared when source k is granted.
  - If a new edge and the grant-clear occur in the same cycle, set wins and the event is kept.
- **Eligible set:** `PEND & MASK`. The highest priority is the lowest index, chosen by a priority encoder.
- **I flag:**
  - `I_CLR` has priority over `I_SET`.
  - Cleared on grant.
  - Set in RESTORE.
- **FSM states:** IDLE, REQ, SAVE, ISR, RESTORE.
  - IDLE: if `I_FLAG && |eligible && FETCH`, go to REQ.
  - REQ: `INTR_REQ` = 1.
    - If `INTR_ACK`: latch `INTR_VEC = VEC_BASE + idx`, clear `PEND[idx]`, clear `I_FLAG`, go to SAVE.
    - Else if `I_CLR` or the eligible set becomes empty: go to IDLE and drop `INTR_REQ`.
  - SAVE: `FLG_SHAD_LD` = 1 for exactly one cycle, then go to ISR.
  - ISR: `IN_ISR` = 1; on `RETIE`, go to RESTORE.
    - `I_SET` inside ISR sets `I_FLAG`, but no request is raised until IDLE (no nesting).
  - RESTORE: `FLG_LD_SEL` = 1 and `FLG_RESTORE` = 1 for one cycle; set `I_FLAG`; go to IDLE.
- **Edge cases:**
  - `RETIE` outside ISR is ignored.
  - `INTR_ACK` outside REQ is ignored.
- **Reset values:**
  - State = IDLE.
  - `PEND` = 0, `IRQ` history = 0.
  - `I_FLAG` = 0.
  - `INTR_VEC` = `VEC_BASE`.
  - `INTR_REQ`, `IN_ISR`, `FLG_SHAD_LD`, `FLG_LD_SEL`, `FLG_RESTORE` = 0.
- **Reset mid-ISR:** returns to IDLE with no restore strobe; the flags are left as they are.

## Timing
- All outputs are registered state decodes; there are no combinational input-to-output paths.
- IRQ edge at cycle t: `PEND` is visible at t+1.
- `FETCH` with an eligible source at cycle t: `INTR_REQ` is high from t+1.
- `INTR_ACK` at cycle a:
  - `INTR_VEC` is valid from a+1.
  - `FLG_SHAD_LD` is high during a+1; the shadow captures at the end of a+1.
  - The control unit must not load the flags during a+1.
- `RETIE` at cycle r:
  - Restore strobes are high during r+1.
  - Flags hold the shadow values from r+2.
  - `I_FLAG` = 1 from r+2.
- Minimum entry-to-exit sequence is 4 cycles: REQ, SAVE, ISR, RESTORE.

## Configuration
- `INTR_EDGE_EN` defined:
  - Edge-detect logic and the `PEND` latch are present as described above.
- `INTR_EDGE_EN` undefined:
  - Level-sensitive: eligible = `IRQ & MASK` directly.
  - No pending storage and no clear-on-grant; the source must deassert its line before RETIE.

## Structure
- **Package `intr_pkg`:**
  - `intr_state_t` enum (IDLE, REQ, SAVE, ISR, RESTORE).
  - `VEC_W_DEF` and `VEC_BASE_DEF` constants.
  - `MAX_SRC` = 8.
- **Sub-module `intr_prio_enc`:** combinational lowest-index-first encoder with outputs `valid` and `idx[$clog2(N_SRC)]`, instantiated once.

## Test plan
- Basic entry and exit:
  - Stimulus: `I_FLAG` = 1, `MASK` = 4'b1111, rising edge on `IRQ[2]`, `FETCH`, then `INTR_ACK`.
  - Required: `INTR_VEC` = 10'h3FA, `FLG_SHAD_LD` pulses once, `I_FLAG` = 0.
  - Then `RETIE`: `FLG_LD_SEL` and `FLG_RESTORE` pulse together and `I_FLAG` = 1 at r+2.
- Priority:
  - Stimulus: edges on `IRQ[3]` and `IRQ[1]` in the same cycle.
  - Required: first grant vector 10'h3F9, second grant 10'h3FB after RETIE, `PEND` = 0 at the end.
- Mask and disable:
  - Stimulus: `MASK[0]` = 0 with an edge on `IRQ[0]`; `INTR_REQ` stays 0.
  - Then set `MASK[0]` = 1 with `I_FLAG` = 0: still no request.
  - Then `I_SET`: `INTR_REQ` is high after the next `FETCH`.
- Withdraw:
  - Stimulus: `I_CLR` pulse while in REQ without ACK.
  - Required: `INTR_REQ` drops the next cycle, `PEND` is retained, no shadow load occurs.
- Simultaneous events:
  - Stimulus: a new edge on `IRQ[1]` in the same cycle as the grant of source 1.
  - Required: `PEND[1]` stays 1 and is serviced again after RETIE.
- Reset mid-ISR:
  - Stimulus: `RST` asserted while in ISR.
  - Required: IDLE, all outputs at reset values, no `FLG_RESTORE`, `INTR_VEC` = 10'h3F8.
